// File: rtl/fp_rr_arbiter_gen2.sv
// -----------------------------------------------------------------------------
// fp_rr_arbiter_gen2
// Two-class (H = time-triggered, L = rate-constrained/best-effort) grant
// arbiter with fixed priority between classes, round-robin inside each class,
// a bounded H streak while L is waiting, an offer timeout and a one-cycle
// guard gap between grants.
//
// Parameters
//   N_H   : number of H channels (1..8)
//   N_L   : number of L channels (1..8)
//   MAX_H : consecutive H services allowed while any L is ready (0 = strict)
//   TMO   : cycles an offered grant waits for go before it is withdrawn
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   bool_ready_H : per-channel request, H class
//   bool_go_H    : per-channel transmitting indication, H class
//   bool_ready_L : per-channel request, L class
//   bool_go_L    : per-channel transmitting indication, L class
//   ena_n_H      : active-low grant, H class
//   ena_n_L      : active-low grant, L class
//   active       : granted class, 00 none / 01 H / 10 L
//   channel      : granted index within its class, 0 when nothing granted
//   err_go       : one-cycle pulse after a stray or multiple go
// -----------------------------------------------------------------------------
module fp_rr_arbiter_gen2 #(
  parameter int N_H   = 1,
  parameter int N_L   = 3,
  parameter int MAX_H = 4,
  parameter int TMO   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N_H-1:0] bool_ready_H,
  input  logic [N_H-1:0] bool_go_H,
  input  logic [N_L-1:0] bool_ready_L,
  input  logic [N_L-1:0] bool_go_L,
  output logic [N_H-1:0] ena_n_H,
  output logic [N_L-1:0] ena_n_L,
  output logic [1:0]     active,
  output logic [3:0]     channel,
  output logic           err_go
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    BUSY  = 2'd2
  } state_t;

  localparam logic [1:0] ACT_NONE = 2'b00;
  localparam logic [1:0] ACT_H    = 2'b01;
  localparam logic [1:0] ACT_L    = 2'b10;

  state_t         state_q, state_d;
  logic [N_H-1:0] ena_n_H_q, ena_n_H_d;
  logic [N_L-1:0] ena_n_L_q, ena_n_L_d;
  logic [1:0]     active_q, active_d;
  logic [3:0]     channel_q, channel_d;
  logic           err_go_q, err_go_d;
  logic [3:0]     h_streak_q, h_streak_d;
  logic [7:0]     wait_q, wait_d;
  logic [2:0]     ptr_H_q, ptr_H_d;
  logic [2:0]     ptr_L_q, ptr_L_d;
  // Holds off granting for the first edge after reset release.
  logic           post_rst_q;

  // Inputs and grants widened to 8 bits so variable indexing is uniform.
  logic [7:0]  rdy_h8_s, rdy_l8_s, go_h8_s, go_l8_s, gnt_h8_s, gnt_l8_s;
  logic [15:0] go_all_s, gnt_all_s;
  logic        any_h_s, any_l_s, sel_l_s;
  logic [2:0]  pick_h_s, pick_l_s;
  logic [7:0]  oh_h_s, oh_l_s;
  logic        granted_go_s, granted_ready_s, release_s;

  assign rdy_h8_s  = 8'(bool_ready_H);
  assign rdy_l8_s  = 8'(bool_ready_L);
  assign go_h8_s   = 8'(bool_go_H);
  assign go_l8_s   = 8'(bool_go_L);
  assign gnt_h8_s  = 8'(~ena_n_H_q);
  assign gnt_l8_s  = 8'(~ena_n_L_q);
  assign go_all_s  = {go_l8_s, go_h8_s};
  assign gnt_all_s = {gnt_l8_s, gnt_h8_s};

  // Round-robin search per class: start at ptr+1, first ready channel wins.
  always_comb begin
    int idx;
    idx      = 0;
    any_h_s  = 1'b0;
    pick_h_s = 3'd0;
    any_l_s  = 1'b0;
    pick_l_s = 3'd0;
    for (int i = 0; i < N_H; i++) begin
      idx      = (int'(ptr_H_q) + 1 + i) % N_H;
      pick_h_s = (!any_h_s && rdy_h8_s[idx[2:0]]) ? idx[2:0] : pick_h_s;
      any_h_s  = any_h_s | rdy_h8_s[idx[2:0]];
    end
    for (int i = 0; i < N_L; i++) begin
      idx      = (int'(ptr_L_q) + 1 + i) % N_L;
      pick_l_s = (!any_l_s && rdy_l8_s[idx[2:0]]) ? idx[2:0] : pick_l_s;
      any_l_s  = any_l_s | rdy_l8_s[idx[2:0]];
    end
  end

  // L wins when no H is asking, or when the H streak budget is used up.
  assign sel_l_s = any_l_s &&
                   (!any_h_s || ((MAX_H != 0) && (h_streak_q == 4'(MAX_H))));
  assign oh_h_s  = 8'd1 << pick_h_s;
  assign oh_l_s  = 8'd1 << pick_l_s;

  // Go/ready of the currently granted channel (from registered grant state).
  assign granted_go_s = |(go_all_s & gnt_all_s);

  // Ready of the granted channel, looked up by class and index.
  always_comb begin
    case (active_q)
      ACT_H:   granted_ready_s = rdy_h8_s[channel_q[2:0]];
      ACT_L:   granted_ready_s = rdy_l8_s[channel_q[2:0]];
      default: granted_ready_s = 1'b0;
    endcase
  end

  // Stray go (not the granted channel) or more than one go raises err_go.
  assign err_go_d = (|(go_all_s & ~gnt_all_s)) ||
                    ((go_all_s & (go_all_s - 16'd1)) != 16'd0);

  // Next-state and next-output logic of the grant FSM.
  always_comb begin
    state_d    = state_q;
    ena_n_H_d  = ena_n_H_q;
    ena_n_L_d  = ena_n_L_q;
    active_d   = active_q;
    channel_d  = channel_q;
    wait_d     = wait_q;
    ptr_H_d    = ptr_H_q;
    ptr_L_d    = ptr_L_q;
    h_streak_d = h_streak_q;
    release_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if ((any_h_s || any_l_s) && !post_rst_q) begin
          state_d = OFFER;
          wait_d  = 8'd0;
          if (sel_l_s) begin
            active_d  = ACT_L;
            channel_d = {1'b0, pick_l_s};
            ena_n_L_d = ~oh_l_s[N_L-1:0];
            ena_n_H_d = '1;
          end else begin
            active_d  = ACT_H;
            channel_d = {1'b0, pick_h_s};
            ena_n_H_d = ~oh_h_s[N_H-1:0];
            ena_n_L_d = '1;
          end
        end else begin
          release_s = 1'b1;
        end
      end
      OFFER: begin
        if (granted_go_s) begin
          state_d = BUSY;
          if (active_q == ACT_H) begin
            ptr_H_d = channel_q[2:0];
            // Streak only counts H services that actually kept L waiting.
            if (any_l_s) begin
              h_streak_d = (h_streak_q >= 4'(MAX_H)) ? 4'(MAX_H)
                                                     : h_streak_q + 4'd1;
            end else begin
              h_streak_d = 4'd0;
            end
          end else begin
            ptr_L_d    = channel_q[2:0];
            h_streak_d = 4'd0;
          end
        end else if (!granted_ready_s) begin
          state_d   = IDLE;
          release_s = 1'b1;
        end else if (wait_q == 8'(TMO - 1)) begin
          // Withdraw and move the pointer past the unresponsive channel.
          state_d   = IDLE;
          release_s = 1'b1;
          if (active_q == ACT_H) begin
            ptr_H_d = channel_q[2:0];
          end else begin
            ptr_L_d = channel_q[2:0];
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      BUSY: begin
        if (!granted_go_s) begin
          state_d   = IDLE;
          release_s = 1'b1;
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d   = IDLE;
        release_s = 1'b1;
      end
    endcase

    ena_n_H_d = release_s ? '1       : ena_n_H_d;
    ena_n_L_d = release_s ? '1       : ena_n_L_d;
    active_d  = release_s ? ACT_NONE : active_d;
    channel_d = release_s ? 4'd0     : channel_d;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ena_n_H_q  <= '1;
      ena_n_L_q  <= '1;
      active_q   <= ACT_NONE;
      channel_q  <= 4'd0;
      err_go_q   <= 1'b0;
      h_streak_q <= 4'd0;
      wait_q     <= 8'd0;
      ptr_H_q    <= 3'(N_H - 1);
      ptr_L_q    <= 3'(N_L - 1);
      post_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ena_n_H_q  <= ena_n_H_d;
      ena_n_L_q  <= ena_n_L_d;
      active_q   <= active_d;
      channel_q  <= channel_d;
      err_go_q   <= err_go_d;
      h_streak_q <= h_streak_d;
      wait_q     <= wait_d;
      ptr_H_q    <= ptr_H_d;
      ptr_L_q    <= ptr_L_d;
      post_rst_q <= 1'b0;
    end
  end

  assign ena_n_H = ena_n_H_q;
  assign ena_n_L = ena_n_L_q;
  assign active  = active_q;
  assign channel = channel_q;
  assign err_go  = err_go_q;

endmodule

// File: tb/tb_fp_rr_arbiter_gen2.sv
// -----------------------------------------------------------------------------
// tb_fp_rr_arbiter_gen2
// Directed bench for fp_rr_arbiter_gen2. Main instance uses defaults
// (N_H=1, N_L=3, MAX_H=4, TMO=8); a second instance with MAX_H=0 runs
// alongside with H0 and L1 permanently ready and an automatic go responder.
// -----------------------------------------------------------------------------
module tb_fp_rr_arbiter_gen2;

  logic       clk;
  logic       rst;
  logic [0:0] ready_H, go_H, ena_n_H;
  logic [2:0] ready_L, go_L, ena_n_L;
  logic [1:0] active;
  logic [3:0] channel;
  logic       err_go;

  logic [0:0] ready_H2, go_H2, ena_n_H2;
  logic [2:0] ready_L2, go_L2, ena_n_L2;
  logic [1:0] active2;
  logic [3:0] channel2;
  logic       err_go2;

  int n_total;
  int n_pass;
  int h_cnt2;
  int l_cnt2;
  int g_act;
  int g_ch;

  fp_rr_arbiter_gen2 #(.N_H(1), .N_L(3), .MAX_H(4), .TMO(8)) u_dut (
    .clk(clk), .rst(rst),
    .bool_ready_H(ready_H), .bool_go_H(go_H),
    .bool_ready_L(ready_L), .bool_go_L(go_L),
    .ena_n_H(ena_n_H), .ena_n_L(ena_n_L),
    .active(active), .channel(channel), .err_go(err_go)
  );

  fp_rr_arbiter_gen2 #(.N_H(1), .N_L(3), .MAX_H(0), .TMO(8)) u_dut_sp (
    .clk(clk), .rst(rst),
    .bool_ready_H(ready_H2), .bool_go_H(go_H2),
    .bool_ready_L(ready_L2), .bool_go_L(go_L2),
    .ena_n_H(ena_n_H2), .ena_n_L(ena_n_L2),
    .active(active2), .channel(channel2), .err_go(err_go2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Wait (bounded) for any grant to show up on the main instance.
  task automatic wait_grant(output int act, output int ch);
    act = 0;
    ch  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (active != 2'b00) begin
        act = int'(active);
        ch  = int'(channel);
        return;
      end
    end
    chk("grant_timeout", 0, 1);
  endtask

  // Pulse go on the granted channel after 'dly' cycles, then check the gap.
  task automatic finish_grant(input int act, input int ch, input int dly,
                              input bit drop, input string tag);
    if (act == 0) return;
    repeat (dly) @(negedge clk);
    if (act == 1) go_H = 1'b1;
    else          go_L = 3'b001 << ch;
    @(negedge clk);
    chk({tag, "_busy"}, int'(active), act);
    go_H = 1'b0;
    go_L = 3'b000;
    if (drop) begin
      ready_H = 1'b0;
      ready_L = 3'b000;
    end
    @(negedge clk);
    chk({tag, "_gap"}, int'(active), 0);
  endtask

  task automatic serve(input int exp_act, input int exp_ch, input int dly,
                       input bit drop, input string tag);
    wait_grant(g_act, g_ch);
    chk({tag, "_act"}, g_act, exp_act);
    chk({tag, "_ch"}, g_ch, exp_ch);
    finish_grant(g_act, g_ch, dly, drop, tag);
  endtask

  // Automatic responder for the strict-priority instance.
  initial begin
    bit busy2;
    busy2 = 1'b0;
    go_H2 = 1'b0;
    go_L2 = 3'b000;
    ready_H2 = 1'b1;
    ready_L2 = 3'b010;
    h_cnt2 = 0;
    l_cnt2 = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        go_H2 = 1'b0;
        go_L2 = 3'b000;
        busy2 = 1'b0;
      end else if (!busy2 && (active2 != 2'b00)) begin
        go_H2 = ~ena_n_H2;
        go_L2 = ~ena_n_L2;
        busy2 = 1'b1;
        if (active2 == 2'b10) l_cnt2++;
        else                  h_cnt2++;
      end else begin
        go_H2 = 1'b0;
        go_L2 = 3'b000;
        busy2 = 1'b0;
      end
    end
  end

  initial begin
    int cnt;
    int exp_a[10];
    int exp_c[10];
    exp_a = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    exp_c = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    n_total = 0;
    n_pass  = 0;
    rst     = 1'b1;
    ready_H = 1'b0;
    go_H    = 1'b0;
    ready_L = 3'b000;
    go_L    = 3'b000;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ena_h", int'(ena_n_H), 1);
    chk("rst_ena_l", int'(ena_n_L), 7);
    chk("rst_active", int'(active), 0);
    chk("rst_channel", int'(channel), 0);
    chk("rst_err", int'(err_go), 0);
    rst = 1'b0;

    // L0/L2 alternate, go 3 cycles after each grant
    ready_L = 3'b101;
    serve(2, 0, 3, 1'b0, "rr0");
    serve(2, 2, 3, 1'b0, "rr1");
    serve(2, 0, 3, 1'b0, "rr2");
    serve(2, 2, 3, 1'b1, "rr3");

    // H0 and L1 continuously ready: four H services then one L1
    ready_H = 1'b1;
    ready_L = 3'b010;
    for (int k = 0; k < 10; k++) begin
      serve(exp_a[k], exp_c[k], 0, (k == 9), "streak");
    end

    // Stray go from L0 while H0 is busy
    ready_H = 1'b1;
    wait_grant(g_act, g_ch);
    chk("err_grant", g_act, 1);
    go_H = 1'b1;
    @(negedge clk);
    go_L = 3'b001;
    @(negedge clk);
    chk("err_pulse", int'(err_go), 1);
    chk("err_active", int'(active), 1);
    chk("err_ena_h", int'(ena_n_H), 0);
    chk("err_ena_l", int'(ena_n_L), 7);
    go_L = 3'b000;
    @(negedge clk);
    chk("err_clear", int'(err_go), 0);
    chk("err_hold", int'(active), 1);
    go_H = 1'b0;
    ready_H = 1'b0;
    @(negedge clk);
    chk("err_release", int'(active), 0);

    // L0 never answers: offered for exactly TMO cycles, then L1 next
    ready_L = 3'b011;
    wait_grant(g_act, g_ch);
    chk("tmo_ch", g_ch, 0);
    cnt = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ena_n_L[0] == 1'b0) cnt++;
      else break;
    end
    chk("tmo_len", cnt, 8);
    chk("tmo_idle", int'(active), 0);
    serve(2, 1, 1, 1'b1, "tmo_next");

    // Ready withdrawn during offer: same pointer, same channel again
    ready_L = 3'b100;
    wait_grant(g_act, g_ch);
    chk("drop_ch", g_ch, 2);
    ready_L = 3'b000;
    @(negedge clk);
    chk("drop_ena_l", int'(ena_n_L), 7);
    chk("drop_active", int'(active), 0);
    ready_L = 3'b101;
    wait_grant(g_act, g_ch);
    chk("drop_regrant", g_ch, 2);
    finish_grant(g_act, g_ch, 1, 1'b1, "drop");

    // Reset while busy on L2
    ready_L = 3'b100;
    wait_grant(g_act, g_ch);
    chk("rb_ch", g_ch, 2);
    go_L = 3'b100;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rb_ena_l", int'(ena_n_L), 7);
    chk("rb_ena_h", int'(ena_n_H), 1);
    chk("rb_active", int'(active), 0);
    chk("rb_channel", int'(channel), 0);
    go_L = 3'b000;
    ready_L = 3'b101;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rb_first_edge", int'(active), 0);
    @(negedge clk);
    chk("rb_grant_act", int'(active), 2);
    chk("rb_grant_ch", int'(channel), 0);
    finish_grant(2, 0, 1, 1'b1, "rb");

    // Strict-priority instance: L1 never served
    repeat (4) @(negedge clk);
    chk("sp_l_never", l_cnt2, 0);
    chk("sp_h_served", int'(h_cnt2 >= 10), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
